// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: forwarding, load/branch stalls, exception drain FSM.
// Ports: register numbers and control flags in; forward selects, stalls, flushes, status out.
module pipe_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int NUM_LONG = 3,
  parameter int WDOG_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_W-1:0]    rsD,
  input  logic [REG_W-1:0]    rtD,
  input  logic [REG_W-1:0]    rsE,
  input  logic [REG_W-1:0]    rtE,
  input  logic [REG_W-1:0]    writeregE,
  input  logic [REG_W-1:0]    writeregM,
  input  logic [REG_W-1:0]    writeregW,
  input  logic                branchD,
  input  logic                jrD,
  input  logic                regwriteE,
  input  logic                memtoregE,
  input  logic                regwriteM,
  input  logic                memtoregM,
  input  logic                regwriteW,
  input  logic [NUM_LONG-1:0] long_req,
  input  logic                is_exceptM,
  output logic                forwardaD,
  output logic                forwardbD,
  output logic [1:0]          forwardaE,
  output logic [1:0]          forwardbE,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                stallM,
  output logic                stallW,
  output logic                flushF,
  output logic                flushD,
  output logic                flushE,
  output logic                flushM,
  output logic                flushW,
  output logic                longest_stall,
  output logic                except_pending,
  output logic                wdog_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, nextState;

  logic              longReq;
  logic              lwStall;
  logic              brStall;
  logic              hazard;
  logic              normal;
  logic              stallAll;
  logic              flushAll;
  logic [WDOG_W-1:0] wdogCnt;
  logic              wdogHit;

  logic rsDnz, rtDnz, rsEnz, rtEnz;

  assign rsDnz = (rsD != '0);
  assign rtDnz = (rtD != '0);
  assign rsEnz = (rsE != '0);
  assign rtEnz = (rtE != '0);

  assign forwardaD = rsDnz && (rsD == writeregM) && regwriteM;
  assign forwardbD = rtDnz && (rtD == writeregM) && regwriteM;

  always_comb begin
    forwardaE = 2'b00;
    if (rsEnz && rsE == writeregM && regwriteM)
      forwardaE = 2'b10;
    else if (rsEnz && rsE == writeregW && regwriteW)
      forwardaE = 2'b01;
  end

  always_comb begin
    forwardbE = 2'b00;
    if (rtEnz && rtE == writeregM && regwriteM)
      forwardbE = 2'b10;
    else if (rtEnz && rtE == writeregW && regwriteW)
      forwardbE = 2'b01;
  end

  assign lwStall = memtoregE &&
    ((rsDnz && rsD == rtE) || (rtDnz && rtD == rtE));

  assign brStall = (branchD || jrD) && (
    (regwriteE &&
      ((rsDnz && rsD == writeregE) || (rtDnz && rtD == writeregE))) ||
    (memtoregM &&
      ((rsDnz && rsD == writeregM) || (rtDnz && rtD == writeregM))));

  // Both hazards collapse into one bubble request.
  assign hazard = lwStall | brStall;

  assign longReq       = |long_req;
  assign longest_stall = longReq | (state == DRAIN);
  assign except_pending = (state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    normal    = 1'b1;
    stallAll  = 1'b0;
    flushAll  = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_exceptM) begin
          normal = 1'b0;
          if (longReq) begin
            // Cannot flush under an outstanding long op; freeze until it drains.
            stallAll  = 1'b1;
            nextState = DRAIN;
          end else begin
            flushAll = 1'b1;
          end
        end
      end
      DRAIN: begin
        normal   = 1'b0;
        stallAll = 1'b1;
        if (!longReq) nextState = FLUSH;
      end
      FLUSH: begin
        normal    = 1'b0;
        flushAll  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (rst) begin
      normal   = 1'b0;
      stallAll = 1'b0;
      flushAll = 1'b1;
    end
  end

  assign stallD = stallAll | (normal & (hazard | longest_stall));
  assign stallF = stallD;
  assign stallE = stallAll | (normal & longest_stall);
  assign stallM = stallE;
  assign stallW = stallE;

  assign flushF = flushAll;
  assign flushD = flushAll;
  assign flushE = flushAll | (normal & hazard & ~longest_stall);
  assign flushM = flushAll;
  assign flushW = flushAll;

  assign wdogHit = (wdogCnt == {WDOG_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdogCnt      <= '0;
      wdog_timeout <= 1'b0;
    end else begin
      if (wdogHit) wdog_timeout <= 1'b1;
      if (!longest_stall)
        wdogCnt <= '0;
      else if (!wdogHit)
        wdogCnt <= wdogCnt + 1'b1;
    end
  end

endmodule
